dtw_accel_seq_ctrl: RTL and testbench
=====================================

// Module: dtw_accel_seq_ctrl
// PURPOSE
//  Sequencer between the AXIS sink FIFO (8-bit samples) and the DTW core. Per job: pops qry_len
//  samples into the core's query buffer, pulses core_start, then streams ref_len samples to the
//  core over valid/ready. Waits for core_done, captures score and cycle count, and reports
//  done/err/abort to the AXI-lite register bank. Job lengths are latched at start.
// PARAMETERS
//  DATA_WIDTH      8   sample width; equals sink FIFO dout width
//  QRY_ADDR_WIDTH  8   query buffer address width; max query 2**QRY_ADDR_WIDTH samples
//  LEN_WIDTH       16  width of qry_len/ref_len and sample counters
//  SCORE_WIDTH     32  DTW score width
//  CYC_WIDTH       32  job cycle counter width
// PORTS
//  ACLK            in   1               clock
//  ARESET          in   1               synchronous reset, active-high
//  start           in   1               job start pulse; ignored while busy
//  abort           in   1               abort current job
//  qry_len         in   LEN_WIDTH       query sample count; sampled on accepted start
//  ref_len         in   LEN_WIDTH       reference sample count; sampled on accepted start
//  dtw_fifo_rden   out  1               pop sink FIFO this cycle
//  dtw_fifo_dout   in   DATA_WIDTH      FIFO head, valid when !dtw_fifo_empty
//  dtw_fifo_empty  in   1               FIFO empty
//  qry_we          out  1               query buffer write enable
//  qry_addr        out  QRY_ADDR_WIDTH  query buffer address
//  qry_data        out  DATA_WIDTH      query buffer write data
//  core_start      out  1               one-cycle pulse: query loaded
//  core_abort      out  1               one-cycle pulse: job aborted
//  ref_valid       out  1               reference sample valid
//  ref_data        out  DATA_WIDTH      reference sample
//  ref_last        out  1               final reference sample
//  ref_ready       in   1               core accepts reference sample
//  core_done       in   1               core finished; core_score valid this cycle
//  core_score      in   SCORE_WIDTH     DTW result
//  busy            out  1               job in progress
//  done            out  1               one-cycle pulse: job complete
//  aborted         out  1               one-cycle pulse: abort taken
//  cfg_err         out  1               sticky: last start rejected
//  score           out  SCORE_WIDTH     last captured score
//  job_cycles      out  CYC_WIDTH       cycles from start accept to done; saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE; counters, lengths, score, job_cycles, cfg_err and all outputs 0.
//  States: IDLE, LOAD_QRY, STREAM_REF, WAIT_DONE. busy = (state != IDLE).
//  IDLE: on start, check qry_len!=0, qry_len<=2**QRY_ADDR_WIDTH and ref_len!=0.
//    Valid: latch lengths, clear cnt and job_cycles, clear cfg_err, go to LOAD_QRY.
//    Invalid: cfg_err<=1, stay IDLE, no done pulse.
//  LOAD_QRY: pop = !dtw_fifo_empty; dtw_fifo_rden = qry_we = pop (combinational).
//    qry_addr = cnt[QRY_ADDR_WIDTH-1:0]; qry_data = dtw_fifo_dout. cnt increments per pop.
//    Pop with cnt==qry_len-1: cnt<=0, go to STREAM_REF, core_start registered high 1 cycle.
//  STREAM_REF: ref_valid = !dtw_fifo_empty; ref_data = dtw_fifo_dout.
//    ref_last = ref_valid && cnt==ref_len-1.
//    dtw_fifo_rden = ref_valid && ref_ready; a handshake is one pop plus cnt+1.
//    Handshake with ref_last: go to WAIT_DONE. ref_valid never depends on ref_ready.
//  WAIT_DONE: rden=0. On core_done: score<=core_score, done<=1 (1 cycle), go to IDLE.
//    core_done outside WAIT_DONE is ignored.
//  job_cycles: increments every busy cycle, saturating. Holds after done or abort.
//  abort while busy: next cycle state IDLE, core_abort=1 and aborted=1 (1 cycle each), cnt<=0.
//    FIFO is not flushed; score is unchanged. abort in IDLE is ignored.
//    abort and core_done in the same cycle: abort wins, no done, score unchanged.
//  Same-cycle start and abort in IDLE: start is processed.
//  start while busy is ignored; latched lengths are unaffected.
//  Empty FIFO stalls LOAD_QRY and STREAM_REF indefinitely, with no timeout.
//  Never pop when dtw_fifo_empty=1.
//  ARESET mid-job returns to IDLE with no done/aborted pulse.
// TESTING
//  T1 qry_len=4, ref_len=6, FIFO preloaded 10 bytes 0x01..0x0A, ref_ready=1:
//     qry writes addr0..3 = 01..04; core_start once;
//     ref 05..0A, ref_last on 0A; core_done score=0x1234 -> score=0x1234, one done pulse.
//  T2 same job, FIFO empty for 3 cycles mid-query and ref_ready toggling 1010:
//     no pop while empty; ref_data held stable while ref_valid && !ref_ready; same results as T1.
//  T3 start with qry_len=0, then ref_len=0, then qry_len=2**QRY_ADDR_WIDTH+1:
//     cfg_err=1, busy=0, no rden; next valid start clears cfg_err.
//  T4 qry_len=2**QRY_ADDR_WIDTH:
//     last write at addr all-ones, no wrap to 0 before core_start.
//  T5 abort during STREAM_REF after 2 samples:
//     core_abort and aborted 1 cycle, busy=0 next cycle, score unchanged;
//     remaining FIFO data still present.
//  T6 abort and core_done same cycle in WAIT_DONE -> aborted only;
//     start during busy ignored; ARESET mid-LOAD_QRY -> all outputs 0.

Source files
------------

// File: rtl/dtw_accel_seq_ctrl.sv
// Job sequencer between the AXIS sink FIFO and the DTW core.
// Loads the query buffer, starts the core, streams the reference samples,
// then captures the score and the job cycle count.
module dtw_accel_seq_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned QRY_ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned SCORE_WIDTH    = 32,
  parameter int unsigned CYC_WIDTH      = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  input  logic                      abort,
  input  logic [LEN_WIDTH-1:0]      qry_len,
  input  logic [LEN_WIDTH-1:0]      ref_len,
  output logic                      dtw_fifo_rden,
  input  logic [DATA_WIDTH-1:0]     dtw_fifo_dout,
  input  logic                      dtw_fifo_empty,
  output logic                      qry_we,
  output logic [QRY_ADDR_WIDTH-1:0] qry_addr,
  output logic [DATA_WIDTH-1:0]     qry_data,
  output logic                      core_start,
  output logic                      core_abort,
  output logic                      ref_valid,
  output logic [DATA_WIDTH-1:0]     ref_data,
  output logic                      ref_last,
  input  logic                      ref_ready,
  input  logic                      core_done,
  input  logic [SCORE_WIDTH-1:0]    core_score,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      cfg_err,
  output logic [SCORE_WIDTH-1:0]    score,
  output logic [CYC_WIDTH-1:0]      job_cycles
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_LOAD_QRY   = 2'd1;
  localparam logic [1:0] S_STREAM_REF = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  // One bit wider than the length ports so a full 2**QRY_ADDR_WIDTH query is representable.
  localparam logic [LEN_WIDTH:0] QRY_MAX = (LEN_WIDTH+1)'(2**QRY_ADDR_WIDTH);

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] qlen_r;
  logic [LEN_WIDTH-1:0] rlen_r;

  logic in_load;
  logic in_stream;
  logic qry_pop;
  logic ref_hs;
  logic start_ok;

  // Datapath strobes derived from the current state and FIFO status.
  always_comb begin
    in_load       = (state == S_LOAD_QRY);
    in_stream     = (state == S_STREAM_REF);
    qry_pop       = in_load && !dtw_fifo_empty;
    ref_valid     = in_stream && !dtw_fifo_empty;
    ref_hs        = ref_valid && ref_ready;
    ref_last      = ref_valid && (cnt == rlen_r - LEN_WIDTH'(1));
    dtw_fifo_rden = qry_pop || ref_hs;
    qry_we        = qry_pop;
    qry_addr      = in_load ? cnt[QRY_ADDR_WIDTH-1:0] : '0;
    qry_data      = in_load ? dtw_fifo_dout : '0;
    ref_data      = in_stream ? dtw_fifo_dout : '0;
    busy          = (state != S_IDLE);
    start_ok      = (qry_len != '0) && ({1'b0, qry_len} <= QRY_MAX) && (ref_len != '0);
  end

  // Job FSM, counters, status pulses and result capture.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      qlen_r     <= '0;
      rlen_r     <= '0;
      score      <= '0;
      job_cycles <= '0;
      cfg_err    <= 1'b0;
      core_start <= 1'b0;
      core_abort <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_abort <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      if (busy && job_cycles != '1) begin
        job_cycles <= job_cycles + CYC_WIDTH'(1);
      end
      // Abort takes priority over any same-cycle progress, including core_done.
      if (busy && abort) begin
        state      <= S_IDLE;
        cnt        <= '0;
        core_abort <= 1'b1;
        aborted    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (start_ok) begin
                qlen_r     <= qry_len;
                rlen_r     <= ref_len;
                cnt        <= '0;
                job_cycles <= '0;
                cfg_err    <= 1'b0;
                state      <= S_LOAD_QRY;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          S_LOAD_QRY: begin
            if (qry_pop) begin
              if (cnt == qlen_r - LEN_WIDTH'(1)) begin
                cnt        <= '0;
                core_start <= 1'b1;
                state      <= S_STREAM_REF;
              end else begin
                cnt <= cnt + LEN_WIDTH'(1);
              end
            end
          end
          S_STREAM_REF: begin
            if (ref_hs) begin
              cnt <= cnt + LEN_WIDTH'(1);
              if (ref_last) begin
                state <= S_WAIT_DONE;
              end
            end
          end
          S_WAIT_DONE: begin
            if (core_done) begin
              score <= core_score;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dtw_accel_seq_ctrl.sv
// Directed bench for dtw_accel_seq_ctrl with a behavioural sink FIFO and event logger.
module tb_dtw_accel_seq_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] qry_len = '0;
  logic [15:0] ref_len = '0;
  logic        dtw_fifo_rden;
  logic [7:0]  dtw_fifo_dout;
  logic        dtw_fifo_empty;
  logic        qry_we;
  logic [7:0]  qry_addr;
  logic [7:0]  qry_data;
  logic        core_start;
  logic        core_abort;
  logic        ref_valid;
  logic [7:0]  ref_data;
  logic        ref_last;
  logic        ref_ready = 1'b1;
  logic        core_done = 1'b0;
  logic [31:0] core_score = '0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cfg_err;
  logic [31:0] score;
  logic [31:0] job_cycles;

  dtw_accel_seq_ctrl #(
    .DATA_WIDTH(8), .QRY_ADDR_WIDTH(8), .LEN_WIDTH(16), .SCORE_WIDTH(32), .CYC_WIDTH(32)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
    .qry_len(qry_len), .ref_len(ref_len),
    .dtw_fifo_rden(dtw_fifo_rden), .dtw_fifo_dout(dtw_fifo_dout), .dtw_fifo_empty(dtw_fifo_empty),
    .qry_we(qry_we), .qry_addr(qry_addr), .qry_data(qry_data),
    .core_start(core_start), .core_abort(core_abort),
    .ref_valid(ref_valid), .ref_data(ref_data), .ref_last(ref_last), .ref_ready(ref_ready),
    .core_done(core_done), .core_score(core_score),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err),
    .score(score), .job_cycles(job_cycles)
  );

  always #5 ACLK = ~ACLK;

  // Sink FIFO model
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic stall = 1'b0;
  logic flush_req = 1'b0;
  logic pop_pend = 1'b0;

  assign dtw_fifo_empty = (rd_ptr == wr_ptr) || stall;
  assign dtw_fifo_dout  = mem[rd_ptr];

  always @(posedge ACLK) begin
    if (flush_req) rd_ptr <= wr_ptr;
    else if (pop_pend) rd_ptr <= rd_ptr + 1;
  end

  // Event logger, sampled mid-cycle
  logic [7:0] qw_addr [0:1023];
  logic [7:0] qw_data [0:1023];
  logic [7:0] rl_data [0:1023];
  logic       rl_last [0:1023];
  int qw_n = 0, rl_n = 0, pop_n = 0, pop_empty_n = 0, unstable_n = 0;
  int cs_n = 0, ca_n = 0, done_n = 0, ab_n = 0;
  logic hold_prev = 1'b0;
  logic [7:0] hold_val = '0;

  always @(negedge ACLK) begin
    pop_pend = dtw_fifo_rden;
    if (dtw_fifo_rden) pop_n++;
    if (dtw_fifo_rden && dtw_fifo_empty) pop_empty_n++;
    if (qry_we) begin qw_addr[qw_n] = qry_addr; qw_data[qw_n] = qry_data; qw_n++; end
    if (ref_valid && ref_ready) begin rl_data[rl_n] = ref_data; rl_last[rl_n] = ref_last; rl_n++; end
    if (hold_prev && ref_valid && ref_data != hold_val) unstable_n++;
    hold_prev = ref_valid && !ref_ready;
    hold_val  = ref_data;
    if (core_start) cs_n++;
    if (core_abort) ca_n++;
    if (done) done_n++;
    if (aborted) ab_n++;
  end

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) push(8'(first + i));
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic do_start(input int q, input int r);
    qry_len = 16'(q);
    ref_len = 16'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_refs(input int target, input bit toggle);
    for (int i = 0; i < 2000; i++) begin
      if (rl_n >= target) break;
      if (toggle) ref_ready = ~ref_ready;
      tick();
    end
    ref_ready = 1'b1;
  endtask

  task automatic finish_job(input logic [31:0] sc);
    core_score = sc;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic check_std_job(input string t, input int qb, input int rb);
    check_val({t, "_qcount"}, 64'(qw_n - qb), 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_q%0d", t, i), {qw_addr[qb+i], qw_data[qb+i]}, {8'(i), 8'(i + 1)});
    end
    check_val({t, "_rcount"}, 64'(rl_n - rb), 6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("%s_r%0d", t, i), {rl_data[rb+i], 7'd0, rl_last[rb+i]},
                {8'(i + 5), 7'd0, (i == 5)});
    end
  endtask

  int qb, rb, cs0, d0, a0, ca0, p0;
  int bad_addr;

  initial begin
    // Reset
    repeat (3) tick();
    ARESET = 1'b0;
    check_val("rst_flags", {busy, done, aborted, cfg_err, core_start, core_abort,
                            qry_we, ref_valid, ref_last, dtw_fifo_rden}, '0);
    check_val("rst_score", score, 0);
    check_val("rst_cycles", job_cycles, 0);
    check_val("rst_data", {qry_addr, qry_data, ref_data}, 0);

    // T1: basic job
    push_seq(1, 10);
    qb = qw_n; rb = rl_n; cs0 = cs_n; d0 = done_n;
    do_start(4, 6);
    check_val("T1_busy", busy, 1);
    wait_refs(rb + 6, 1'b0);
    check_val("T1_busy_wait", busy, 1);
    finish_job(32'h1234);
    check_val("T1_done", {done, busy}, 2'b10);
    check_val("T1_score", score, 32'h1234);
    check_val("T1_cycles", job_cycles, 11);
    tick();
    check_val("T1_done_pulse", done, 0);
    check_val("T1_cycles_hold", job_cycles, 11);
    check_val("T1_cs_n", 64'(cs_n - cs0), 1);
    check_val("T1_done_n", 64'(done_n - d0), 1);
    check_std_job("T1", qb, rb);

    // T2: FIFO stall mid-query, ref_ready toggling
    push_seq(1, 10);
    qb = qw_n; rb = rl_n; cs0 = cs_n; d0 = done_n;
    do_start(4, 6);
    tick(); tick();
    stall = 1'b1;
    p0 = pop_n;
    repeat (3) tick();
    stall = 1'b0;
    check_val("T2_stall_nopop", 64'(pop_n - p0), 0);
    check_val("T2_stall_q", 64'(qw_n - qb), 2);
    wait_refs(rb + 6, 1'b1);
    finish_job(32'h1234);
    check_val("T2_done", {done, busy}, 2'b10);
    check_val("T2_score", score, 32'h1234);
    check_val("T2_cs_n", 64'(cs_n - cs0), 1);
    check_val("T2_unstable", unstable_n, 0);
    check_std_job("T2", qb, rb);
    tick();

    // T3: rejected starts, each followed by a valid start that clears cfg_err
    for (int k = 0; k < 3; k++) begin
      logic [15:0] bq, br;
      bq = (k == 0) ? 16'd0 : (k == 1) ? 16'd4 : 16'd257;
      br = (k == 1) ? 16'd0 : 16'd6;
      flush();
      push_seq(8'h40, 2);
      p0 = pop_n; d0 = done_n;
      do_start(int'(bq), int'(br));
      check_val($sformatf("T3_err%0d", k), {cfg_err, busy}, 2'b10);
      tick(); tick();
      check_val($sformatf("T3_nopop%0d", k), 64'(pop_n - p0), 0);
      check_val($sformatf("T3_nodone%0d", k), 64'(done_n - d0), 0);
      do_start(4, 6);
      check_val($sformatf("T3_clr%0d", k), {cfg_err, busy}, 2'b01);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val($sformatf("T3_abort%0d", k), {busy, aborted}, 2'b01);
    end
    flush();

    // T4: full-size query
    qb = qw_n; rb = rl_n;
    push_seq(0, 256);
    push_seq(8'h77, 2);
    do_start(256, 2);
    wait_refs(rb + 2, 1'b0);
    finish_job(32'hCAFE);
    check_val("T4_qcount", 64'(qw_n - qb), 256);
    bad_addr = 0;
    for (int i = 0; i < 256; i++) begin
      if (qw_addr[qb+i] != 8'(i) || qw_data[qb+i] != 8'(i)) bad_addr++;
    end
    check_val("T4_addr_seq", bad_addr, 0);
    check_val("T4_last_addr", qw_addr[qb+255], 8'hFF);
    check_val("T4_ref", {rl_data[rb], rl_data[rb+1], 6'd0, rl_last[rb], rl_last[rb+1]},
              {8'h77, 8'h78, 6'd0, 1'b0, 1'b1});
    check_val("T4_score", score, 32'hCAFE);
    check_val("T4_cycles", job_cycles, 259);
    tick();

    // T5: abort during reference stream after 2 samples
    flush();
    push_seq(1, 10);
    rb = rl_n; d0 = done_n; a0 = ab_n; ca0 = ca_n;
    do_start(4, 6);
    wait_refs(rb + 2, 1'b0);
    ref_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("T5_pulses", {aborted, core_abort, busy, done}, 4'b1100);
    check_val("T5_score", score, 32'hCAFE);
    check_val("T5_fifo_left", 64'(wr_ptr - rd_ptr), 4);
    check_val("T5_fifo_head", dtw_fifo_dout, 8'h07);
    check_val("T5_cycles", job_cycles, 7);
    tick();
    ref_ready = 1'b1;
    check_val("T5_pulse_end", {aborted, core_abort}, 2'b00);
    check_val("T5_cycles_hold", job_cycles, 7);
    check_val("T5_counts", {8'(rl_n - rb), 8'(ab_n - a0), 8'(ca_n - ca0), 8'(done_n - d0)},
              {8'd2, 8'd1, 8'd1, 8'd0});

    // T6: start while busy ignored; abort beats core_done
    flush();
    push_seq(1, 10);
    qb = qw_n; rb = rl_n; d0 = done_n; a0 = ab_n;
    do_start(4, 6);
    do_start(1, 1);
    wait_refs(rb + 6, 1'b0);
    core_score = 32'hBEEF;
    core_done = 1'b1;
    abort = 1'b1;
    tick();
    core_done = 1'b0;
    abort = 1'b0;
    check_val("T6_abort_win", {aborted, done, busy}, 3'b100);
    check_val("T6_score", score, 32'hCAFE);
    tick();
    check_val("T6_counts", {8'(done_n - d0), 8'(ab_n - a0)}, {8'd0, 8'd1});
    check_std_job("T6", qb, rb);

    // ARESET mid-LOAD_QRY
    flush();
    push_seq(1, 4);
    d0 = done_n; a0 = ab_n;
    do_start(4, 6);
    tick();
    check_val("T6_in_load", {busy, qry_we}, 2'b11);
    ARESET = 1'b1;
    tick();
    check_val("T6_rst_flags", {busy, done, aborted, cfg_err, core_start, core_abort,
                               qry_we, ref_valid, ref_last, dtw_fifo_rden}, '0);
    check_val("T6_rst_vals", {score, job_cycles}, '0);
    check_val("T6_rst_data", {qry_addr, qry_data, ref_data}, 0);
    ARESET = 1'b0;
    tick();
    check_val("T6_rst_nopulse", {8'(done_n - d0), 8'(ab_n - a0), 7'd0, busy}, '0);
    check_val("pop_when_empty", pop_empty_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
